lbr_dump_engine: RTL and testbench

//  Downstream consumer of the LBR unit. On a start request, freezes LBR recording, then walks the

---
 rtl/lbr_pkg.sv | 22 ++
 rtl/lbr_dump_engine.sv | 124 ++++++++++++
 tb/tb_lbr_dump_engine.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/lbr_pkg.sv
// Definitions shared by the LBR unit and its dump engine: dump FSM states,
// read-bank selects and the TOS register address.
package lbr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_TOS,
    RD_FROM,
    RD_TO,
    EMIT,
    FIN
  } lbr_dump_state_e;

  localparam logic [1:0] LBR_BANK_FROM = 2'b00;
  localparam logic [1:0] LBR_BANK_TO   = 2'b01;

  // TOS lives at the top bit of the LBR address space, above both banks.
  function automatic int unsigned lbr_tos_addr(input int unsigned aw);
    return 32'd1 << (aw - 1);
  endfunction

endpackage

// File: rtl/lbr_dump_engine.sv
// Freezes the LBR, walks the ring newest-to-oldest and streams {from,to,index}
// records over a valid/ready port, then releases the freeze.
module lbr_dump_engine
  import lbr_pkg::*;
#(
  parameter int  DATA_WIDTH   = 32,
  parameter int  ADDRESS_BITS = 20,
  parameter int  LBR_SIZE     = 16,
  localparam int IDX_W        = $clog2(LBR_SIZE),
  localparam int LBR_AW       = IDX_W + 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  output logic [LBR_AW-1:0]       lbr_rd_addr,
  input  logic [DATA_WIDTH-1:0]   lbr_rd_data,
  output logic                    lbr_freeze,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDRESS_BITS-1:0] out_from,
  output logic [ADDRESS_BITS-1:0] out_to,
  output logic [IDX_W-1:0]        out_index,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);

  localparam logic [LBR_AW-1:0] TOS_ADDR = LBR_AW'(lbr_tos_addr(LBR_AW));

  lbr_dump_state_e         state_q, state_d;
  logic [LBR_AW-1:0]       rd_addr_q, rd_addr_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic [ADDRESS_BITS-1:0] from_q, from_d;
  logic [ADDRESS_BITS-1:0] to_q, to_d;
  logic                    last;

  logic unused_rd_bits;
  assign unused_rd_bits = ^lbr_rd_data[DATA_WIDTH-1:ADDRESS_BITS];

  assign last = (cnt_q == IDX_W'(LBR_SIZE - 1));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    from_d  = from_q;
    to_d    = to_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) state_d = RD_TOS;
      end
      RD_TOS: begin
        ptr_d   = lbr_rd_data[IDX_W-1:0];
        cnt_d   = '0;
        state_d = RD_FROM;
      end
      RD_FROM: begin
        from_d  = lbr_rd_data[ADDRESS_BITS-1:0];
        state_d = RD_TO;
      end
      RD_TO: begin
        to_d    = lbr_rd_data[ADDRESS_BITS-1:0];
        state_d = EMIT;
      end
      EMIT: begin
        if (out_ready) begin
          if (last) begin
            state_d = FIN;
          end else begin
            // Ring walks backwards in age; the IDX_W-bit subtract wraps 0 -> LBR_SIZE-1.
            ptr_d   = ptr_q - IDX_W'(1);
            cnt_d   = cnt_q + IDX_W'(1);
            state_d = RD_FROM;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) state_d = IDLE;
  end

  // Read select is registered from the next state so it is valid for the whole
  // cycle the combinational read data is sampled, and can reset to zero.
  always_comb begin
    rd_addr_d = TOS_ADDR;
    case (state_d)
      RD_FROM: rd_addr_d = {LBR_BANK_FROM, ptr_d};
      RD_TO:   rd_addr_d = {LBR_BANK_TO, ptr_d};
      default: rd_addr_d = TOS_ADDR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  // Record/pointer registers are always loaded before use, so they carry no reset.
  always_ff @(posedge clock) begin
    ptr_q  <= ptr_d;
    cnt_q  <= cnt_d;
    from_q <= from_d;
    to_q   <= to_d;
  end

  assign lbr_rd_addr = rd_addr_q;
  assign busy        = (state_q != IDLE);
  assign lbr_freeze  = busy;
  assign done        = (state_q == FIN);
  assign out_valid   = (state_q == EMIT);
  assign out_from    = out_valid ? from_q : '0;
  assign out_to      = out_valid ? to_q : '0;
  assign out_index   = out_valid ? cnt_q : '0;
  assign out_last    = out_valid & last;

endmodule

// File: tb/tb_lbr_dump_engine.sv
// Directed/randomized bench for lbr_dump_engine with a behavioural LBR ring
// that serves the read port and records branches unless frozen.
module tb_lbr_dump_engine;

  logic        clock = 1'b0;
  logic        reset, start, abort, out_ready;
  logic [5:0]  lbr_rd_addr;
  logic [31:0] lbr_rd_data;
  logic        lbr_freeze, out_valid, out_last, busy, done;
  logic [19:0] out_from, out_to;
  logic [3:0]  out_index;

  logic [19:0] from_m [16];
  logic [19:0] to_m   [16];
  logic [3:0]  tos;
  logic        br_en;
  logic [19:0] br_from, br_to;

  int npass = 0;
  int ntot  = 0;
  int nfail = 0;

  lbr_dump_engine dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .lbr_rd_addr(lbr_rd_addr),
    .lbr_rd_data(lbr_rd_data),
    .lbr_freeze (lbr_freeze),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_from   (out_from),
    .out_to     (out_to),
    .out_index  (out_index),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  // LBR read port: TOS at address bit 5, TO bank at bit 4, FROM bank otherwise.
  // Upper bits carry junk so the engine's field slicing is exercised.
  always_comb begin
    lbr_rd_data = 32'hA5A0_0000;
    if (lbr_rd_addr[5])      lbr_rd_data = {28'hDEADBEE, tos};
    else if (lbr_rd_addr[4]) lbr_rd_data = {12'hA5A, to_m[lbr_rd_addr[3:0]]};
    else                     lbr_rd_data = {12'h5A5, from_m[lbr_rd_addr[3:0]]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    ntot++;
    assert (obs === want) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, want);
    end
  endtask

  // One clock; a pending branch is recorded at the edge only if the LBR was not frozen.
  task automatic tick();
    logic fz;
    fz = lbr_freeze;
    @(posedge clock);
    #1;
    if (br_en && !fz) begin
      tos         = tos + 4'd1;
      from_m[tos] = br_from;
      to_m[tos]   = br_to;
    end
    br_en = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_freeze"}, lbr_freeze, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_addr"}, lbr_rd_addr, 0);
    check({tag, "_from"}, out_from, 0);
    check({tag, "_to"}, out_to, 0);
    check({tag, "_index"}, out_index, 0);
    check({tag, "_last"}, out_last, 0);
  endtask

  // stall < 0 picks a random 0..3 cycle stall per record; abort_idx < 0 means no abort.
  task automatic run_dump(input int stall, input int abort_idx, input bit br_start,
                          input bit br_frozen, input bit restart);
    logic [19:0] ef [16];
    logic [19:0] et [16];
    int  got, cyc, st, want, last_acc;
    bit  acc, fin, saw;
    start = 1'b1;
    if (br_start) begin
      br_en   = 1'b1;
      br_from = 20'($urandom);
      br_to   = 20'($urandom);
    end
    tick();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      ef[k] = from_m[4'(tos - 4'(k))];
      et[k] = to_m[4'(tos - 4'(k))];
    end
    got = 0; cyc = 1; st = 0; last_acc = -1; fin = 1'b0;
    want = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
    while (cyc < 3000) begin
      acc = 1'b0;
      out_ready = 1'b1;
      if (done) begin
        fin = 1'b1;
        break;
      end
      if (out_valid) begin
        check("rec_from", out_from, ef[got]);
        check("rec_to", out_to, et[got]);
        check("rec_index", out_index, got);
        check("rec_last", out_last, (got == 15));
        check("rec_freeze", lbr_freeze, 1);
        if (got == abort_idx) begin
          abort = 1'b1;
          tick();
          abort = 1'b0;
          check("abort_valid", out_valid, 0);
          check("abort_freeze", lbr_freeze, 0);
          check("abort_busy", busy, 0);
          check("abort_done", done, 0);
          saw = 1'b0;
          repeat (60) begin
            tick();
            if (done) saw = 1'b1;
          end
          check("abort_no_done", saw, 0);
          return;
        end
        if (st < want) begin
          out_ready = 1'b0;
          st++;
        end else begin
          acc  = 1'b1;
          st   = 0;
          want = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
        end
      end
      if (br_frozen && cyc == 10) begin
        check("freeze_at_branch", lbr_freeze, 1);
        br_en   = 1'b1;
        br_from = 20'($urandom);
        br_to   = 20'($urandom);
      end
      if (restart && cyc == 20) start = 1'b1;
      tick();
      start = 1'b0;
      cyc++;
      if (acc) begin
        got++;
        last_acc = cyc;
      end
    end
    check("done_seen", fin, 1);
    check("record_count", got, 16);
    check("done_after_last", cyc, last_acc);
    if (stall == 0) check("latency", cyc, 50);
    tick();
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    check("post_freeze", lbr_freeze, 0);
    check("post_addr", lbr_rd_addr, 6'h20);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    br_en = 1'b0; br_from = '0; br_to = '0; tos = 4'd5;
    for (int i = 0; i < 16; i++) begin
      from_m[i] = 20'h100 + 20'(i);
      to_m[i]   = 20'h200 + 20'(i);
    end
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();
    check("idle_addr", lbr_rd_addr, 6'h20);

    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", busy, 0);
    tick();
    check("start_abort_idle2", busy, 0);

    run_dump(0, -1, 1'b0, 1'b0, 1'b0);
    run_dump(7, -1, 1'b0, 1'b0, 1'b0);
    run_dump(0, 3, 1'b0, 1'b0, 1'b0);
    run_dump(0, -1, 1'b0, 1'b0, 1'b0);
    run_dump(0, -1, 1'b1, 1'b1, 1'b0);
    run_dump(0, -1, 1'b0, 1'b0, 1'b1);

    for (int r = 0; r < 3; r++) begin
      tos = 4'($urandom);
      for (int i = 0; i < 16; i++) begin
        from_m[i] = 20'($urandom);
        to_m[i]   = 20'($urandom);
      end
      run_dump(-1, -1, 1'($urandom), 1'b0, 1'b0);
    end

    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("rd_to_addr", lbr_rd_addr, {2'b01, tos});
    reset = 1'b1;
    tick();
    check_all_zero("midreset");
    reset = 1'b0;
    tick();
    check("midreset_idle_addr", lbr_rd_addr, 6'h20);
    check("midreset_busy", busy, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
